// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 key-search controller and its S-port mux.
package rc4_pkg;

    localparam int KEY_WIDTH_DEF = 24;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN_INIT = 3'd1,
        RUN_KSA  = 3'd2,
        RUN_DEC  = 3'd3,
        NEXT_KEY = 3'd4,
        FOUND    = 3'd5,
        FAIL     = 3'd6
    } search_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        INIT = 2'd1,
        KSA  = 2'd2,
        DEC  = 2'd3
    } s_owner_t;

    // Plaintext alphabet: space or lower-case letters.
    function automatic logic is_valid_char(input logic [7:0] c);
        return (c == 8'h20) || ((c >= 8'h61) && (c <= 8'h7A));
    endfunction

endpackage

// File: rtl/rc4_key_search_ctrl_s_port_mux.sv
// Combinational grant of the single-port S-memory to the engine that owns it.
module s_port_mux
    import rc4_pkg::*;
(
    input  s_owner_t   sel_i,
    input  logic [7:0] init_addr_i,
    input  logic [7:0] init_data_i,
    input  logic       init_wren_i,
    input  logic [7:0] ksa_addr_i,
    input  logic [7:0] ksa_data_i,
    input  logic       ksa_wren_i,
    input  logic [7:0] dec_addr_i,
    input  logic [7:0] dec_data_i,
    input  logic       dec_wren_i,
    output logic [7:0] addr_o,
    output logic [7:0] data_o,
    output logic       wren_o
);

    always_comb begin
        addr_o = '0;
        data_o = '0;
        wren_o = 1'b0;
        case (sel_i)
            INIT: begin
                addr_o = init_addr_i;
                data_o = init_data_i;
                wren_o = init_wren_i;
            end
            KSA: begin
                addr_o = ksa_addr_i;
                data_o = ksa_data_i;
                wren_o = ksa_wren_i;
            end
            DEC: begin
                addr_o = dec_addr_i;
                data_o = dec_data_i;
                wren_o = dec_wren_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Sequences init / KSA / decrypt per candidate key, grants the S-port and
// walks the key space until a printable message appears or keys run out.
module rc4_key_search_ctrl
    import rc4_pkg::*;
#(
    parameter int                   KEY_WIDTH     = KEY_WIDTH_DEF,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX       = 'h3FFFFF,
    parameter int                   MSG_LEN       = 32,
    parameter int                   PHASE_TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 init_start,
    output logic                 ksa_start,
    output logic                 dec_start,
    input  logic                 init_finish,
    input  logic                 ksa_finish,
    input  logic                 dec_finish,
    input  logic [7:0]           init_address,
    input  logic [7:0]           ksa_address,
    input  logic [7:0]           dec_address,
    input  logic [7:0]           init_data,
    input  logic [7:0]           ksa_data,
    input  logic [7:0]           dec_data,
    input  logic                 init_wren,
    input  logic                 ksa_wren,
    input  logic                 dec_wren,
    output logic [7:0]           s_address,
    output logic [7:0]           s_data,
    output logic                 s_wren,
    input  logic [7:0]           dec_data_ram,
    input  logic                 dec_wren_ram,
    output logic [KEY_WIDTH-1:0] key,
    output logic                 busy,
    output logic                 found,
    output logic                 fail,
    output logic                 timeout
);

    localparam int WD_W = $clog2(PHASE_TIMEOUT + 1);
    localparam int WC_W = $clog2(MSG_LEN + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(PHASE_TIMEOUT - 1);
    localparam logic [WC_W-1:0] WC_FULL = WC_W'(MSG_LEN);

    search_state_t        state_q, state_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic [WD_W-1:0]      wdog_q, wdog_d;
    logic [WC_W-1:0]      wr_cnt_q, wr_cnt_d;
    logic                 found_q, found_d, fail_q, fail_d, tmo_q, tmo_d;
    logic                 init_start_q, ksa_start_q, dec_start_q, busy_q;
    logic                 running, wdog_hit, bad_char;
    s_owner_t             owner;

    assign running  = (state_q == RUN_INIT) || (state_q == RUN_KSA) || (state_q == RUN_DEC);
    assign wdog_hit = running && (wdog_q == WD_LAST);
    // Only the first MSG_LEN result writes are message bytes.
    assign bad_char = dec_wren_ram && (wr_cnt_q != WC_FULL) && !is_valid_char(dec_data_ram);

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        found_d  = found_q;
        fail_d   = fail_q;
        tmo_d    = tmo_q;
        case (state_q)
            IDLE, FOUND, FAIL: begin
                if (start) begin
                    key_d   = '0;
                    found_d = 1'b0;
                    fail_d  = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = RUN_INIT;
                end
            end
            RUN_INIT: if (init_finish) state_d = RUN_KSA;
            RUN_KSA:  if (ksa_finish)  state_d = RUN_DEC;
            RUN_DEC: begin
                if (bad_char) begin
                    state_d = NEXT_KEY;
                end else if (dec_finish) begin
                    state_d = FOUND;
                    found_d = 1'b1;
                end
            end
            NEXT_KEY: begin
                if (key_q == KEY_MAX) begin
                    state_d = FAIL;
                    fail_d  = 1'b1;
                end else begin
                    key_d   = key_q + KEY_WIDTH'(1);
                    state_d = RUN_INIT;
                end
            end
            default: state_d = IDLE;
        endcase
        // Watchdog fires only when the phase made no progress this cycle.
        if (wdog_hit && (state_d == state_q)) begin
            state_d = FAIL;
            fail_d  = 1'b1;
            tmo_d   = 1'b1;
        end
    end

    always_comb begin
        wdog_d = (running && (state_d == state_q)) ? wdog_q + WD_W'(1) : '0;
        wr_cnt_d = '0;
        if (state_q == RUN_DEC)
            wr_cnt_d = (dec_wren_ram && (wr_cnt_q != WC_FULL)) ? wr_cnt_q + WC_W'(1) : wr_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            key_q        <= '0;
            wdog_q       <= '0;
            wr_cnt_q     <= '0;
            found_q      <= 1'b0;
            fail_q       <= 1'b0;
            tmo_q        <= 1'b0;
            init_start_q <= 1'b0;
            ksa_start_q  <= 1'b0;
            dec_start_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            wdog_q       <= wdog_d;
            wr_cnt_q     <= wr_cnt_d;
            found_q      <= found_d;
            fail_q       <= fail_d;
            tmo_q        <= tmo_d;
            init_start_q <= (state_d == RUN_INIT);
            ksa_start_q  <= (state_d == RUN_KSA);
            dec_start_q  <= (state_d == RUN_DEC);
            busy_q       <= (state_d == RUN_INIT) || (state_d == RUN_KSA) ||
                            (state_d == RUN_DEC)  || (state_d == NEXT_KEY);
        end
    end

    always_comb begin
        case (state_q)
            RUN_INIT: owner = INIT;
            RUN_KSA:  owner = KSA;
            RUN_DEC:  owner = DEC;
            default:  owner = NONE;
        endcase
    end

    s_port_mux u_s_port_mux (
        .sel_i       (owner),
        .init_addr_i (init_address),
        .init_data_i (init_data),
        .init_wren_i (init_wren),
        .ksa_addr_i  (ksa_address),
        .ksa_data_i  (ksa_data),
        .ksa_wren_i  (ksa_wren),
        .dec_addr_i  (dec_address),
        .dec_data_i  (dec_data),
        .dec_wren_i  (dec_wren),
        .addr_o      (s_address),
        .data_o      (s_data),
        .wren_o      (s_wren)
    );

    assign init_start = init_start_q;
    assign ksa_start  = ksa_start_q;
    assign dec_start  = dec_start_q;
    assign key        = key_q;
    assign busy       = busy_q;
    assign found      = found_q;
    assign fail       = fail_q;
    assign timeout    = tmo_q;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Behavioural engines plus table-driven and randomized searches for rc4_key_search_ctrl.
module tb_rc4_key_search_ctrl;

    localparam int              KW   = 24;
    localparam logic [KW-1:0]   KMAX = 24'd5;
    localparam int              PT   = 64;
    localparam int              ML   = 32;
    localparam int              NK   = 6;

    logic clk = 1'b0;
    logic reset, start;
    logic init_start, ksa_start, dec_start;
    logic init_finish, ksa_finish, dec_finish;
    logic [7:0] init_address, ksa_address, dec_address;
    logic [7:0] init_data, ksa_data, dec_data;
    logic init_wren, ksa_wren, dec_wren;
    logic [7:0] s_address, s_data;
    logic s_wren;
    logic [7:0] dec_data_ram;
    logic dec_wren_ram;
    logic [KW-1:0] key;
    logic busy, found, fail, timeout;

    always #5 clk = ~clk;

    rc4_key_search_ctrl #(.KEY_WIDTH(KW), .KEY_MAX(KMAX), .MSG_LEN(ML), .PHASE_TIMEOUT(PT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .init_start(init_start), .ksa_start(ksa_start), .dec_start(dec_start),
        .init_finish(init_finish), .ksa_finish(ksa_finish), .dec_finish(dec_finish),
        .init_address(init_address), .ksa_address(ksa_address), .dec_address(dec_address),
        .init_data(init_data), .ksa_data(ksa_data), .dec_data(dec_data),
        .init_wren(init_wren), .ksa_wren(ksa_wren), .dec_wren(dec_wren),
        .s_address(s_address), .s_data(s_data), .s_wren(s_wren),
        .dec_data_ram(dec_data_ram), .dec_wren_ram(dec_wren_ram),
        .key(key), .busy(busy), .found(found), .fail(fail), .timeout(timeout)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit ref_valid(input int c);
        return (c == 32) || (c >= 97 && c <= 122);
    endfunction

    // Engine configuration
    int   init_lat = 10, ksa_lat = 20;
    bit   ksa_hang = 0, dec_fin_last = 0, stale_fin = 0;
    logic [7:0] msg [0:NK-1][0:ML-1];

    // Monitor results
    int overlap_err, sport_err, nk_cnt, init_runs;
    int init_run, ksa_run, dec_run, init_len, ksa_len, dec_len;
    int ic, kc, dc;

    task automatic clear_mon;
        overlap_err = 0; sport_err = 0; nk_cnt = 0; init_runs = 0;
        init_run = 0; ksa_run = 0; dec_run = 0; init_len = 0; ksa_len = 0; dec_len = 0;
    endtask

    // Monitor samples the stable state first, then engines update their outputs.
    always @(negedge clk) begin
        logic [7:0] ea, ed;
        logic ew;
        int nst, k;
        nst = int'(init_start) + int'(ksa_start) + int'(dec_start);
        if (nst > 1) overlap_err++;
        if (init_start)     begin ea = init_address; ed = init_data; ew = init_wren; end
        else if (ksa_start) begin ea = ksa_address;  ed = ksa_data;  ew = ksa_wren;  end
        else if (dec_start) begin ea = dec_address;  ed = dec_data;  ew = dec_wren;  end
        else                begin ea = 8'h00; ed = 8'h00; ew = 1'b0; end
        if ({s_address, s_data, s_wren} !== {ea, ed, ew}) sport_err++;
        if (busy === 1'b1 && nst == 0) nk_cnt++;
        if (init_start) init_run++; else if (init_run != 0) begin init_len = init_run; init_run = 0; init_runs++; end
        if (ksa_start)  ksa_run++;  else if (ksa_run != 0)  begin ksa_len = ksa_run; ksa_run = 0; end
        if (dec_start)  dec_run++;  else if (dec_run != 0)  begin dec_len = dec_run; dec_run = 0; end

        if (init_start) begin
            init_address = ic[7:0]; init_data = ~ic[7:0]; init_wren = ic[0];
            init_finish = (ic == init_lat - 1); ic++;
        end else begin
            ic = 0; init_address = 8'($urandom); init_data = 8'($urandom);
            init_wren = 1'($urandom); init_finish = stale_fin;
        end
        if (ksa_start) begin
            ksa_address = 8'(kc * 7); ksa_data = kc[7:0]; ksa_wren = ~kc[0];
            ksa_finish = !ksa_hang && (kc == ksa_lat - 1); kc++;
        end else begin
            kc = 0; ksa_address = 8'($urandom); ksa_data = 8'($urandom);
            ksa_wren = 1'($urandom); ksa_finish = stale_fin;
        end
        if (dec_start) begin
            k = (key <= KMAX) ? int'(key) : 0;
            dec_address = dc[7:0]; dec_data = 8'(dc * 3); dec_wren = 1'b1;
            dec_wren_ram = (dc < ML);
            dec_data_ram = (dc < ML) ? msg[k][dc] : 8'h00;
            dec_finish = (dc == (dec_fin_last ? ML - 1 : ML)); dc++;
        end else begin
            dc = 0; dec_address = 8'($urandom); dec_data = 8'($urandom);
            dec_wren = 1'($urandom); dec_wren_ram = 1'($urandom);
            dec_data_ram = 8'h00; dec_finish = stale_fin;
        end
    end

    task automatic build_msgs(input logic [NK-1:0] mask, input int pos, input logic [7:0] chr);
        for (int k = 0; k < NK; k++) begin
            for (int i = 0; i < ML; i++)
                msg[k][i] = (i == 0) ? 8'h20 : (i == 1) ? 8'h61 : (i == 2) ? 8'h7A
                          : 8'(97 + $urandom_range(0, 25));
            if (mask[k]) msg[k][pos] = chr;
        end
    endtask

    task automatic do_start;
        @(negedge clk); #2;
        clear_mon();
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        chk("start_init_start", {31'd0, init_start}, 1);
        chk("start_busy", {31'd0, busy}, 1);
        chk("start_key0", key, 0);
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!(found === 1'b1 || fail === 1'b1) && n < 20000) begin @(negedge clk); n++; end
        if (n >= 20000) begin
            checks++; errors++;
            $display("FAIL %s_done: got no found/fail, expected one within 20000 cycles", nm);
        end
        @(negedge clk); #1;
    endtask

    // Reference: keys are tried in order, the first clean key wins.
    task automatic model(input logic [NK-1:0] mask, output bit f, output int k, output int nk);
        f = 0; k = int'(KMAX); nk = 0;
        for (int i = 0; i <= int'(KMAX); i++) begin
            if (!mask[i]) begin f = 1; k = i; break; end
            nk++;
        end
    endtask

    task automatic run_case(input string nm, input logic [NK-1:0] mask, input int pos,
                            input logic [7:0] chr, input bit fl, input bit ef, input int ek, input int enk);
        build_msgs(mask, pos, chr);
        dec_fin_last = fl;
        do_start();
        wait_done(nm);
        chk({nm, "_found"}, {31'd0, found}, {31'd0, ef});
        chk({nm, "_fail"}, {31'd0, fail}, {31'd0, !ef});
        chk({nm, "_timeout"}, {31'd0, timeout}, 0);
        chk({nm, "_key"}, key, ek);
        chk({nm, "_busy"}, {31'd0, busy}, 0);
        chk({nm, "_next_key_cycles"}, nk_cnt, enk);
        chk({nm, "_keys_tried"}, init_runs, ef ? enk + 1 : enk);
        chk({nm, "_init_len"}, init_len, init_lat);
        chk({nm, "_ksa_len"}, ksa_len, ksa_lat);
        chk({nm, "_overlap"}, overlap_err, 0);
        chk({nm, "_sport"}, sport_err, 0);
    endtask

    typedef struct {
        logic [NK-1:0] mask;
        int            pos;
        logic [7:0]    chr;
        bit            fin_last;
        bit            exp_found;
        int            exp_key;
        int            exp_nk;
    } vec_t;

    initial begin
        vec_t tbl [6];
        bit ef;
        int ek, enk, n;
        logic [NK-1:0] rmask;
        int rpos;
        logic [7:0] rchr;

        tbl[0] = '{6'b000000, 2,  8'h41, 1'b0, 1'b1, 0, 0};
        tbl[1] = '{6'b011111, 2,  8'h41, 1'b0, 1'b1, 5, 5};
        tbl[2] = '{6'b111111, 2,  8'h41, 1'b0, 1'b0, 5, 6};
        tbl[3] = '{6'b000101, 0,  8'h7B, 1'b0, 1'b1, 1, 1};
        tbl[4] = '{6'b000001, 31, 8'h60, 1'b0, 1'b1, 1, 1};
        tbl[5] = '{6'b000011, 31, 8'h1F, 1'b1, 1'b1, 2, 2};

        start = 1'b0; reset = 1'b1;
        init_finish = 0; ksa_finish = 0; dec_finish = 0;
        init_address = 0; ksa_address = 0; dec_address = 0;
        init_data = 0; ksa_data = 0; dec_data = 0;
        init_wren = 0; ksa_wren = 0; dec_wren = 0;
        dec_data_ram = 0; dec_wren_ram = 0;
        clear_mon();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_starts", {29'd0, init_start, ksa_start, dec_start}, 0);
        chk("rst_key", key, 0);
        chk("rst_flags", {28'd0, busy, found, fail, timeout}, 0);
        chk("rst_sport", {15'd0, s_address, s_data, s_wren}, 0);

        // Stale finishes in IDLE must not start anything.
        stale_fin = 1;
        repeat (4) @(negedge clk);
        #1;
        stale_fin = 0;
        chk("stale_idle", {28'd0, init_start, ksa_start, dec_start, busy}, 0);
        chk("stale_idle_sport_wren", {31'd0, s_wren}, 0);

        for (int i = 0; i < 6; i++)
            run_case($sformatf("tbl%0d", i), tbl[i].mask, tbl[i].pos, tbl[i].chr,
                     tbl[i].fin_last, tbl[i].exp_found, tbl[i].exp_key, tbl[i].exp_nk);

        for (int i = 0; i < 5; i++) begin
            rmask = NK'($urandom);
            rpos  = $urandom_range(0, ML - 1);
            do rchr = 8'($urandom); while (ref_valid(int'(rchr)));
            init_lat = $urandom_range(1, 20);
            ksa_lat  = $urandom_range(1, 40);
            model(rmask, ef, ek, enk);
            run_case($sformatf("rnd%0d", i), rmask, rpos, rchr, 1'($urandom), ef, ek, enk);
        end

        // start ignored while busy, then reset mid-KSA on key 1.
        init_lat = 5; ksa_lat = 30;
        build_msgs(6'b000001, 4, 8'h00);
        dec_fin_last = 0;
        do_start();
        n = 0;
        while (!(key == 1 && ksa_start === 1'b1) && n < 2000) begin @(negedge clk); n++; end
        chk("mid_reach_ksa_key1", (n < 2000) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        chk("busy_start_ignored_key", key, 1);
        chk("busy_start_ignored_ksa", {31'd0, ksa_start}, 1);
        reset = 1'b1;
        @(negedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_ksa_start", {31'd0, ksa_start}, 0);
        chk("mid_rst_key", key, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_sport", {15'd0, s_address, s_data, s_wren}, 0);

        // KSA never finishes: watchdog after PT cycles of the phase.
        ksa_hang = 1;
        do_start();
        wait_done("tmo");
        ksa_hang = 0;
        chk("tmo_fail", {31'd0, fail}, 1);
        chk("tmo_timeout", {31'd0, timeout}, 1);
        chk("tmo_found", {31'd0, found}, 0);
        chk("tmo_key", key, 0);
        chk("tmo_ksa_len", ksa_len, PT);
        chk("tmo_sport", sport_err, 0);

        // Restart from FAIL clears the timeout flag.
        init_lat = 12; ksa_lat = 25;
        run_case("restart", 6'b000010, 2, 8'h41, 1'b0, 1'b1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
